// File: rtl/tron_draw_scheduler_if.sv
// Bundle for the draw scheduler: game-side requests in, acks/status and the
// vga_adapter write port out.
//   master : game/timer side (drives tick, clear_req, player requests)
//   slave  : the scheduler (drives acks, status and vga_* write port)
interface tron_draw_scheduler_if #(
  parameter int unsigned X_W = 8,
  parameter int unsigned Y_W = 7
);
  logic           tick;
  logic           clear_req;
  logic           p1_req;
  logic [X_W-1:0] p1_x;
  logic [Y_W-1:0] p1_y;
  logic [2:0]     p1_colour;
  logic           p1_ack;
  logic           p2_req;
  logic [X_W-1:0] p2_x;
  logic [Y_W-1:0] p2_y;
  logic [2:0]     p2_colour;
  logic           p2_ack;
  logic [X_W-1:0] vga_x;
  logic [Y_W-1:0] vga_y;
  logic [2:0]     vga_colour;
  logic           vga_plot;
  logic           busy;
  logic           clear_done;
  logic           tick_miss;

  modport master (
    output tick, clear_req,
    output p1_req, p1_x, p1_y, p1_colour,
    output p2_req, p2_x, p2_y, p2_colour,
    input  p1_ack, p2_ack,
    input  vga_x, vga_y, vga_colour, vga_plot,
    input  busy, clear_done, tick_miss
  );

  modport slave (
    input  tick, clear_req,
    input  p1_req, p1_x, p1_y, p1_colour,
    input  p2_req, p2_x, p2_y, p2_colour,
    output p1_ack, p2_ack,
    output vga_x, vga_y, vga_colour, vga_plot,
    output busy, clear_done, tick_miss
  );
endinterface

// File: rtl/tron_draw_scheduler.sv
// tron_draw_scheduler
// Sole owner of the vga_adapter write port. Shares it between a full-screen
// clear sweep and two players. Each game tick serves the pending player
// writes, alternating which player goes first; a pending clear request
// instead sweeps the whole frame to CLEAR_COLOUR.
// Ports:
//   clk    : system clock
//   resetn : asynchronous active-low reset
//   bus    : slave side of tron_draw_scheduler_if
//            in : tick, clear_req, p{1,2}_req/x/y/colour
//            out: p{1,2}_ack, vga_x/y/colour/plot, busy, clear_done, tick_miss
// All bus outputs are registered; a plot decided in state S appears on the
// vga_* lines in the cycle after S is entered.
module tron_draw_scheduler #(
  parameter int unsigned SCREEN_W     = 160,
  parameter int unsigned SCREEN_H     = 120,
  parameter int unsigned X_W          = 8,
  parameter int unsigned Y_W          = 7,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
  input logic                  clk,
  input logic                  resetn,
  tron_draw_scheduler_if.slave bus
);

  localparam logic [X_W-1:0] XLast = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] YLast = Y_W'(SCREEN_H - 1);

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StFirst,
    StSecond
  } state_e;

  state_e         state_q, state_d;
  logic           clr_pend_q, clr_pend_d;
  // 0: player 1 is served first on the next pass, 1: player 2 first
  logic           first_p2_q, first_p2_d;
  logic [X_W-1:0] cnt_x_q, cnt_x_d;
  logic [Y_W-1:0] cnt_y_q, cnt_y_d;

  logic [X_W-1:0] vga_x_q, vga_x_d;
  logic [Y_W-1:0] vga_y_q, vga_y_d;
  logic [2:0]     vga_colour_q, vga_colour_d;
  logic           vga_plot_q, vga_plot_d;
  logic           p1_ack_q, p1_ack_d;
  logic           p2_ack_q, p2_ack_d;
  logic           tick_miss_q, tick_miss_d;
  // Marks the cycle the final sweep pixel is on the bus; clear_done follows it
  logic           sweep_end_q, sweep_end_d;
  logic           clear_done_q, clear_done_d;

  logic           p1_in_bounds, p2_in_bounds;
  logic           sel_p2;
  logic           sel_req, sel_in_bounds;
  logic [X_W-1:0] sel_x;
  logic [Y_W-1:0] sel_y;
  logic [2:0]     sel_colour;

  assign p1_in_bounds = (32'(bus.p1_x) < SCREEN_W) && (32'(bus.p1_y) < SCREEN_H);
  assign p2_in_bounds = (32'(bus.p2_x) < SCREEN_W) && (32'(bus.p2_y) < SCREEN_H);

  // FIRST serves the player named by first_p2_q, SECOND serves the other one
  assign sel_p2        = (state_q == StSecond) ? ~first_p2_q : first_p2_q;
  assign sel_req       = sel_p2 ? bus.p2_req      : bus.p1_req;
  assign sel_in_bounds = sel_p2 ? p2_in_bounds    : p1_in_bounds;
  assign sel_x         = sel_p2 ? bus.p2_x        : bus.p1_x;
  assign sel_y         = sel_p2 ? bus.p2_y        : bus.p1_y;
  assign sel_colour    = sel_p2 ? bus.p2_colour   : bus.p1_colour;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d      = state_q;
    // A clear request arriving mid-sweep is dropped
    clr_pend_d   = clr_pend_q | (bus.clear_req && (state_q != StClear));
    first_p2_d   = first_p2_q;
    cnt_x_d      = cnt_x_q;
    cnt_y_d      = cnt_y_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    p1_ack_d     = 1'b0;
    p2_ack_d     = 1'b0;
    tick_miss_d  = bus.tick && (state_q != StIdle);
    sweep_end_d  = 1'b0;
    clear_done_d = sweep_end_q;

    case (state_q)
      StIdle: begin
        // clr_pend_q is registered, so a clear_req coinciding with this tick
        // is only seen by the next one
        if (bus.tick) begin
          if (clr_pend_q) begin
            state_d = StClear;
            cnt_x_d = '0;
            cnt_y_d = '0;
          end else begin
            state_d = StFirst;
          end
        end
      end

      StClear: begin
        vga_plot_d   = 1'b1;
        vga_x_d      = cnt_x_q;
        vga_y_d      = cnt_y_q;
        vga_colour_d = CLEAR_COLOUR;
        if (cnt_x_q == XLast) begin
          cnt_x_d = '0;
          if (cnt_y_q == YLast) begin
            cnt_y_d     = '0;
            state_d     = StIdle;
            clr_pend_d  = 1'b0;
            first_p2_d  = 1'b0;
            sweep_end_d = 1'b1;
          end else begin
            cnt_y_d = cnt_y_q + Y_W'(1);
          end
        end else begin
          cnt_x_d = cnt_x_q + X_W'(1);
        end
      end

      StFirst, StSecond: begin
        if (sel_req) begin
          p1_ack_d = ~sel_p2;
          p2_ack_d = sel_p2;
          // Off-screen pixels are consumed but never reach the adapter
          if (sel_in_bounds) begin
            vga_plot_d   = 1'b1;
            vga_x_d      = sel_x;
            vga_y_d      = sel_y;
            vga_colour_d = sel_colour;
          end
        end
        if (state_q == StFirst) begin
          state_d = StSecond;
        end else begin
          state_d    = StIdle;
          first_p2_d = ~first_p2_q;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Bookkeeping and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clr_pend_q   <= 1'b0;
      first_p2_q   <= 1'b0;
      cnt_x_q      <= '0;
      cnt_y_q      <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      p1_ack_q     <= 1'b0;
      p2_ack_q     <= 1'b0;
      tick_miss_q  <= 1'b0;
      sweep_end_q  <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      clr_pend_q   <= clr_pend_d;
      first_p2_q   <= first_p2_d;
      cnt_x_q      <= cnt_x_d;
      cnt_y_q      <= cnt_y_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      p1_ack_q     <= p1_ack_d;
      p2_ack_q     <= p2_ack_d;
      tick_miss_q  <= tick_miss_d;
      sweep_end_q  <= sweep_end_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;
  assign bus.vga_plot   = vga_plot_q;
  assign bus.p1_ack     = p1_ack_q;
  assign bus.p2_ack     = p2_ack_q;
  assign bus.tick_miss  = tick_miss_q;
  assign bus.clear_done = clear_done_q;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_tron_draw_scheduler.sv
// Testbench for tron_draw_scheduler: table of single-tick player passes plus
// hand-written clear, tick-miss, reset-abort and clear/tick-collision runs.
module tb_tron_draw_scheduler;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  tron_draw_scheduler_if bus ();

  tron_draw_scheduler dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int passed = 0;
  int total  = 0;

  typedef struct {
    int p1_req; int p1_x; int p1_y; int p1_c;
    int p2_req; int p2_x; int p2_y; int p2_c;
    int a_plot; int a_ack1; int a_ack2; int a_x; int a_y; int a_c;
    int b_plot; int b_ack1; int b_ack2; int b_x; int b_y; int b_c;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  task automatic set_p1(input int req, input int x, input int y, input int c);
    bus.p1_req = 1'(req); bus.p1_x = 8'(x); bus.p1_y = 7'(y); bus.p1_colour = 3'(c);
  endtask

  task automatic set_p2(input int req, input int x, input int y, input int c);
    bus.p2_req = 1'(req); bus.p2_x = 8'(x); bus.p2_y = 7'(y); bus.p2_colour = 3'(c);
  endtask

  task automatic chk_slot(input string tag, input int plot, input int ack1, input int ack2,
                          input int x, input int y, input int c);
    chk({tag, "_plot"}, int'(bus.vga_plot), plot);
    chk({tag, "_ack1"}, int'(bus.p1_ack), ack1);
    chk({tag, "_ack2"}, int'(bus.p2_ack), ack2);
    chk({tag, "_x"}, int'(bus.vga_x), x);
    chk({tag, "_y"}, int'(bus.vga_y), y);
    chk({tag, "_col"}, int'(bus.vga_colour), c);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int miss_bad;
    int first_bad;

    // First served player alternates P1,P2,P1,... starting with P1 after reset
    vecs[0] = '{1, 5, 5, 5,      1, 112, 111, 3,  1, 1, 0, 5, 5, 5,      1, 0, 1, 112, 111, 3};
    vecs[1] = '{1, 5, 5, 5,      1, 112, 111, 3,  1, 0, 1, 112, 111, 3,  1, 1, 0, 5, 5, 5};
    vecs[2] = '{1, 160, 10, 7,   1, 159, 119, 6,  0, 1, 0, 5, 5, 5,      1, 0, 1, 159, 119, 6};
    vecs[3] = '{1, 0, 0, 1,      0, 0, 0, 0,      0, 0, 0, 159, 119, 6,  1, 1, 0, 0, 0, 1};
    vecs[4] = '{0, 0, 0, 0,      0, 0, 0, 0,      0, 0, 0, 0, 0, 1,      0, 0, 0, 0, 0, 1};
    vecs[5] = '{1, 20, 30, 4,    1, 10, 120, 2,   0, 0, 1, 0, 0, 1,      1, 1, 0, 20, 30, 4};
    vecs[6] = '{0, 0, 0, 0,      1, 1, 2, 3,      0, 0, 0, 20, 30, 4,    1, 0, 1, 1, 2, 3};

    resetn = 1'b0;
    bus.tick = 1'b0;
    bus.clear_req = 1'b0;
    set_p1(0, 0, 0, 0);
    set_p2(0, 0, 0, 0);
    step();
    step();
    resetn = 1'b1;
    step();

    // Reset state
    chk_slot("rst", 0, 0, 0, 0, 0, 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_clear_done", int'(bus.clear_done), 0);
    chk("rst_tick_miss", int'(bus.tick_miss), 0);

    // Table of single-tick passes
    for (int i = 0; i < 7; i++) begin
      set_p1(vecs[i].p1_req, vecs[i].p1_x, vecs[i].p1_y, vecs[i].p1_c);
      set_p2(vecs[i].p2_req, vecs[i].p2_x, vecs[i].p2_y, vecs[i].p2_c);
      pulse_tick();
      chk($sformatf("v%0d_busy", i), int'(bus.busy), 1);
      step();
      chk_slot($sformatf("v%0d_a", i), vecs[i].a_plot, vecs[i].a_ack1, vecs[i].a_ack2,
               vecs[i].a_x, vecs[i].a_y, vecs[i].a_c);
      step();
      chk_slot($sformatf("v%0d_b", i), vecs[i].b_plot, vecs[i].b_ack1, vecs[i].b_ack2,
               vecs[i].b_x, vecs[i].b_y, vecs[i].b_c);
      chk($sformatf("v%0d_idle", i), int'(bus.busy), 0);
    end

    // Full-screen clear with p1 held, a stray tick and a stray clear_req mid-sweep
    set_p1(1, 10, 10, 7);
    set_p2(0, 0, 0, 0);
    bus.clear_req = 1'b1;
    step();
    bus.clear_req = 1'b0;
    pulse_tick();
    chk("clr_busy", int'(bus.busy), 1);
    bad = 0;
    miss_bad = 0;
    first_bad = -1;
    for (int k = 0; k < 19200; k++) begin
      bus.tick = (k == 100);
      bus.clear_req = (k == 200);
      step();
      bus.tick = 1'b0;
      bus.clear_req = 1'b0;
      if (bus.vga_plot !== 1'b1 || int'(bus.vga_x) != k % 160 || int'(bus.vga_y) != k / 160 ||
          bus.vga_colour !== 3'b000 || bus.p1_ack !== 1'b0 || bus.clear_done !== 1'b0 ||
          (k < 19199 && bus.busy !== 1'b1)) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
      if (int'(bus.tick_miss) != int'(k == 100)) miss_bad++;
    end
    if (bad != 0) $display("note: first bad sweep pixel index %0d", first_bad);
    chk("clr_bad_pixels", bad, 0);
    chk("clr_tick_miss_errors", miss_bad, 0);
    step();
    chk("clr_done_pulse", int'(bus.clear_done), 1);
    chk("clr_done_plot", int'(bus.vga_plot), 0);
    chk("clr_done_busy", int'(bus.busy), 0);
    chk("clr_done_p1_ack", int'(bus.p1_ack), 0);
    step();
    chk("clr_done_low", int'(bus.clear_done), 0);

    // Held-off p1 is served by the first tick after the clear; P1 goes first again
    pulse_tick();
    step();
    chk_slot("post_clr_a", 1, 1, 0, 10, 10, 7);
    step();
    chk_slot("post_clr_b", 0, 0, 0, 10, 10, 7);

    // Reset in the middle of a sweep aborts it
    set_p1(0, 0, 0, 0);
    bus.clear_req = 1'b1;
    step();
    bus.clear_req = 1'b0;
    pulse_tick();
    for (int k = 0; k < 5000; k++) step();
    #2;
    resetn = 1'b0;
    #1;
    chk_slot("abort", 0, 0, 0, 0, 0, 0);
    chk("abort_busy", int'(bus.busy), 0);
    step();
    resetn = 1'b1;
    step();
    set_p2(1, 3, 4, 5);
    pulse_tick();
    chk("abort_pass_busy", int'(bus.busy), 1);
    step();
    chk_slot("abort_pass_a", 0, 0, 0, 0, 0, 0);
    step();
    chk_slot("abort_pass_b", 1, 0, 1, 3, 4, 5);

    // clear_req coinciding with tick: the pass runs, the clear waits for the next tick
    set_p2(0, 0, 0, 0);
    set_p1(1, 7, 8, 1);
    bus.clear_req = 1'b1;
    bus.tick = 1'b1;
    step();
    bus.clear_req = 1'b0;
    bus.tick = 1'b0;
    step();
    chk_slot("coll_a", 0, 0, 0, 3, 4, 5);
    step();
    chk_slot("coll_b", 1, 1, 0, 7, 8, 1);
    pulse_tick();
    step();
    chk_slot("coll_clr0", 1, 0, 0, 0, 0, 0);
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    chk_slot("coll_clr1", 1, 0, 0, 1, 0, 0);
    chk("coll_tick_miss", int'(bus.tick_miss), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
